// File: rtl/multdiv_issue.sv
// multdiv_issue: initiator-side controller for the shared multiply/divide unit.
// Accepts one request at a time, launches it with a one-cycle ctrl_MULT/ctrl_DIV
// pulse on stable operands, waits for data_resultRDY and returns the result on a
// valid/ready writeback port. busy stalls the pipeline while a request is in flight.
//
// Optional feature: define MULTDIV_TIMEOUT_EN to enable a watchdog that completes
// the request with an exception after TIMEOUT_CYCLES cycles without data_resultRDY.
// Without it, WAIT lasts indefinitely and wb_timeout is tied low.

module multdiv_issue #(
  parameter int unsigned TAG_W          = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clock,
  input  logic             ctrl_reset_n,
  // request port
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  // multdiv unit
  output logic [31:0]      data_operandA,
  output logic [31:0]      data_operandB,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  input  logic [31:0]      data_result,
  input  logic             data_exception,
  input  logic             data_resultRDY,
  // writeback port
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [31:0]      wb_result,
  output logic             wb_exception,
  output logic [TAG_W-1:0] wb_tag,
  output logic             wb_timeout,
  output logic             busy
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StGuard,
    StWait,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Captured request
  logic             op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [TAG_W-1:0] tag_q;

  // Writeback registers
  logic [31:0]      wb_result_q;
  logic             wb_exception_q;
  logic [TAG_W-1:0] wb_tag_q;

  logic accept;
  logic timeout_hit;

  assign accept = (state_q == StIdle) && req_valid;

`ifdef MULTDIV_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1) + 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wb_timeout_q;

  // Counter is 0 in GUARD, so the last WAIT cycle it may still succeed in holds
  // TIMEOUT_CYCLES-1; a ready in that same cycle still wins in the FSM below.
  assign timeout_hit = (state_q == StWait) &&
                       (cnt_q >= CntW'(TIMEOUT_CYCLES - 1));

  // Watchdog count: clear while issuing, count while waiting for the unit
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIssue) begin
      cnt_d = '0;
    end else if ((state_q == StGuard) || (state_q == StWait)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Watchdog counter register
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Timeout flag is captured together with the rest of the writeback payload
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      wb_timeout_q <= 1'b0;
    end else if (state_q == StWait) begin
      if (data_resultRDY) begin
        wb_timeout_q <= 1'b0;
      end else if (timeout_hit) begin
        wb_timeout_q <= 1'b1;
      end
    end
  end

  assign wb_timeout = wb_timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign wb_timeout  = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; GUARD skips the unit's possibly stale ready from the last op
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = StIssue;
      StIssue: state_d = StGuard;
      StGuard: state_d = StWait;
      StWait:  if (data_resultRDY || timeout_hit) state_d = StDone;
      StDone:  if (wb_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request capture; operands stay frozen until the next acceptance
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      op_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      tag_q <= '0;
    end else if (accept) begin
      op_q  <= req_op;
      a_q   <= req_a;
      b_q   <= req_b;
      tag_q <= req_tag;
    end
  end

  // Writeback payload: loaded on completion or timeout, held through DONE
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      wb_result_q    <= '0;
      wb_exception_q <= 1'b0;
      wb_tag_q       <= '0;
    end else if (state_q == StWait) begin
      if (data_resultRDY) begin
        wb_result_q    <= data_result;
        wb_exception_q <= data_exception;
        wb_tag_q       <= tag_q;
      end else if (timeout_hit) begin
        wb_result_q    <= '0;
        wb_exception_q <= 1'b1;
        wb_tag_q       <= tag_q;
      end
    end
  end

  // Outputs decoded from state and captured registers
  always_comb begin
    req_ready     = (state_q == StIdle);
    busy          = (state_q != StIdle);
    ctrl_MULT     = (state_q == StIssue) && !op_q;
    ctrl_DIV      = (state_q == StIssue) && op_q;
    wb_valid      = (state_q == StDone);
    data_operandA = a_q;
    data_operandB = b_q;
    wb_result     = wb_result_q;
    wb_exception  = wb_exception_q;
    wb_tag        = wb_tag_q;
  end

  // Start pulses are mutually exclusive
  assert property (@(posedge clock) disable iff (!ctrl_reset_n) !(ctrl_MULT && ctrl_DIV));

  // A zero watchdog limit would leave no cycle in which a result can be accepted
  assert property (@(posedge clock) TIMEOUT_CYCLES > 0);

endmodule

// File: tb/tb_multdiv_issue.sv
// Self-checking bench for multdiv_issue: table of directed transactions plus
// hand-written backpressure, reset and watchdog sequences.

module tb_multdiv_issue;

  localparam int unsigned TagW = 5;

  logic            clock = 1'b0;
  logic            ctrl_reset_n;
  logic            req_valid;
  logic            req_ready;
  logic            req_op;
  logic [31:0]     req_a;
  logic [31:0]     req_b;
  logic [TagW-1:0] req_tag;
  logic [31:0]     data_operandA;
  logic [31:0]     data_operandB;
  logic            ctrl_MULT;
  logic            ctrl_DIV;
  logic [31:0]     data_result;
  logic            data_exception;
  logic            data_resultRDY;
  logic            wb_valid;
  logic            wb_ready;
  logic [31:0]     wb_result;
  logic            wb_exception;
  logic [TagW-1:0] wb_tag;
  logic            wb_timeout;
  logic            busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  multdiv_issue #(
    .TAG_W         (TagW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock         (clock),
    .ctrl_reset_n  (ctrl_reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_tag       (req_tag),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_result     (wb_result),
    .wb_exception  (wb_exception),
    .wb_tag        (wb_tag),
    .wb_timeout    (wb_timeout),
    .busy          (busy)
  );

  typedef struct {
    logic            op;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [TagW-1:0] tag;
    int              rdy_cycle;  // cycle (>=3) in which data_resultRDY is driven high
    bit              stale;      // also hold data_resultRDY high in cycles 0..2
    logic [31:0]     res;
    logic            exc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Full transaction starting in IDLE (cycle 0 = acceptance cycle)
  task automatic run_vec(input vec_t v);
    for (int c = 0; c <= v.rdy_cycle; c++) begin
      if (c == 0) begin
        check("idle_req_ready", {31'b0, req_ready}, 32'd1);
        check("idle_busy", {31'b0, busy}, 32'd0);
        req_valid = 1'b1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        req_tag   = v.tag;
      end else begin
        // scramble request inputs to show captured values are used
        req_valid = 1'b0;
        req_op    = ~v.op;
        req_a     = ~v.a;
        req_b     = ~v.b;
        req_tag   = ~v.tag;
        check("busy_high", {31'b0, busy}, 32'd1);
        check("req_ready_low", {31'b0, req_ready}, 32'd0);
        check("ctrl_mult", {31'b0, ctrl_MULT}, {31'b0, (c == 1) && !v.op});
        check("ctrl_div", {31'b0, ctrl_DIV}, {31'b0, (c == 1) && v.op});
        check("operand_a_held", data_operandA, v.a);
        check("operand_b_held", data_operandB, v.b);
        check("wb_valid_early", {31'b0, wb_valid}, 32'd0);
      end
      data_resultRDY = (c == v.rdy_cycle) || (v.stale && c <= 2);
      data_result    = (c == v.rdy_cycle) ? v.res : 32'hbad0_0bad;
      data_exception = (c == v.rdy_cycle) ? v.exc : ~v.exc;
      step();
    end
    data_resultRDY = 1'b0;
    data_result    = 32'h5555_5555;
    data_exception = 1'b0;
    check("wb_valid", {31'b0, wb_valid}, 32'd1);
    check("wb_result", wb_result, v.res);
    check("wb_exception", {31'b0, wb_exception}, {31'b0, v.exc});
    check("wb_tag", {27'b0, wb_tag}, {27'b0, v.tag});
    check("wb_timeout_clear", {31'b0, wb_timeout}, 32'd0);
    check("done_operand_a", data_operandA, v.a);
    check("done_operand_b", data_operandB, v.b);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    check("post_req_ready", {31'b0, req_ready}, 32'd1);
    check("post_busy", {31'b0, busy}, 32'd0);
    check("post_wb_valid", {31'b0, wb_valid}, 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{op: 1'b0, a: 32'd6, b: 32'd7, tag: 5'd3, rdy_cycle: 10, stale: 1'b0,
                res: 32'd42, exc: 1'b0};
    vecs[1] = '{op: 1'b1, a: 32'd100, b: 32'd0, tag: 5'd7, rdy_cycle: 5, stale: 1'b0,
                res: 32'd0, exc: 1'b1};
    vecs[2] = '{op: 1'b0, a: 32'd3, b: 32'd5, tag: 5'd9, rdy_cycle: 8, stale: 1'b1,
                res: 32'd15, exc: 1'b0};
    vecs[3] = '{op: 1'b0, a: 32'hffff_ffff, b: 32'd2, tag: 5'd31, rdy_cycle: 3,
                stale: 1'b0, res: 32'hffff_fffe, exc: 1'b0};
    vecs[4] = '{op: 1'b1, a: 32'd1000, b: 32'd7, tag: 5'd1, rdy_cycle: 4, stale: 1'b0,
                res: 32'd142, exc: 1'b0};
    // ready in the last cycle the watchdog allows (when enabled) is a normal completion
    vecs[5] = '{op: 1'b1, a: 32'd81, b: 32'd9, tag: 5'd12, rdy_cycle: 17, stale: 1'b0,
                res: 32'd9, exc: 1'b0};

    ctrl_reset_n   = 1'b0;
    req_valid      = 1'b0;
    req_op         = 1'b0;
    req_a          = '0;
    req_b          = '0;
    req_tag        = '0;
    data_result    = '0;
    data_exception = 1'b0;
    data_resultRDY = 1'b0;
    wb_ready       = 1'b0;

    // Reset values
    #1;
    check("rst_ctrl_mult", {31'b0, ctrl_MULT}, 32'd0);
    check("rst_ctrl_div", {31'b0, ctrl_DIV}, 32'd0);
    check("rst_operand_a", data_operandA, 32'd0);
    check("rst_operand_b", data_operandB, 32'd0);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_wb_result", wb_result, 32'd0);
    check("rst_wb_exception", {31'b0, wb_exception}, 32'd0);
    check("rst_wb_tag", {27'b0, wb_tag}, 32'd0);
    check("rst_wb_timeout", {31'b0, wb_timeout}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Backpressure: wb_ready low 5 cycles with a new request waiting throughout
    req_valid = 1'b1; req_op = 1'b0; req_a = 32'd11; req_b = 32'd13; req_tag = 5'd4;
    step();                                  // cycle 1
    req_op = 1'b1; req_a = 32'd50; req_b = 32'd5; req_tag = 5'd2;
    step();                                  // cycle 2
    step();                                  // cycle 3
    data_resultRDY = 1'b1; data_result = 32'd143; data_exception = 1'b0;
    step();                                  // cycle 4: DONE
    data_resultRDY = 1'b0; data_result = 32'd0;
    for (int i = 0; i < 5; i++) begin
      check("bp_wb_valid", {31'b0, wb_valid}, 32'd1);
      check("bp_wb_result", wb_result, 32'd143);
      check("bp_wb_tag", {27'b0, wb_tag}, 32'd4);
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
      check("bp_ctrl_div", {31'b0, ctrl_DIV}, 32'd0);
      check("bp_operand_a", data_operandA, 32'd11);
      step();
    end
    check("bp_wb_valid_last", {31'b0, wb_valid}, 32'd1);
    wb_ready = 1'b1;
    step();                                  // IDLE; waiting request accepted at next edge
    wb_ready = 1'b0;
    check("bp_next_req_ready", {31'b0, req_ready}, 32'd1);
    check("bp_next_wb_valid", {31'b0, wb_valid}, 32'd0);
    step();                                  // cycle 1 of second request
    req_valid = 1'b0;
    check("bp2_ctrl_div", {31'b0, ctrl_DIV}, 32'd1);
    check("bp2_ctrl_mult", {31'b0, ctrl_MULT}, 32'd0);
    check("bp2_operand_a", data_operandA, 32'd50);
    check("bp2_operand_b", data_operandB, 32'd5);
    step();                                  // cycle 2
    check("bp2_wb_valid_c2", {31'b0, wb_valid}, 32'd0);
    step();                                  // cycle 3
    check("bp2_wb_valid_c3", {31'b0, wb_valid}, 32'd0);
    data_resultRDY = 1'b1; data_result = 32'd10;
    step();                                  // cycle 4: minimum latency
    data_resultRDY = 1'b0;
    check("bp2_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("bp2_wb_result", wb_result, 32'd10);
    check("bp2_wb_tag", {27'b0, wb_tag}, 32'd2);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    check("bp2_req_ready", {31'b0, req_ready}, 32'd1);

    // Reset while in WAIT
    req_valid = 1'b1; req_op = 1'b0; req_a = 32'd9; req_b = 32'd9; req_tag = 5'd5;
    step();
    req_valid = 1'b0;
    step(); step(); step();                  // cycle 4: WAIT
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    #2 ctrl_reset_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("mid_rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("mid_rst_operand_a", data_operandA, 32'd0);
    #2 ctrl_reset_n = 1'b1;
    step();
    data_resultRDY = 1'b1; data_result = 32'd77;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_rdy_ignored_valid", {31'b0, wb_valid}, 32'd0);
      check("rst_rdy_ignored_busy", {31'b0, busy}, 32'd0);
    end
    data_resultRDY = 1'b0;

    // Request with no ready at all
    req_valid = 1'b1; req_op = 1'b1; req_a = 32'd8; req_b = 32'd2; req_tag = 5'd6;
    step();                                  // cycle 1
    req_valid = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      check("no_rdy_wb_valid", {31'b0, wb_valid}, 32'd0);
      step();
    end                                      // now in cycle 18
`ifdef MULTDIV_TIMEOUT_EN
    check("to_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("to_wb_exception", {31'b0, wb_exception}, 32'd1);
    check("to_wb_timeout", {31'b0, wb_timeout}, 32'd1);
    check("to_wb_result", wb_result, 32'd0);
    check("to_wb_tag", {27'b0, wb_tag}, 32'd6);
    // late ready must not disturb the held writeback
    data_resultRDY = 1'b1; data_result = 32'd99;
    step();
    data_resultRDY = 1'b0;
    check("to_late_result", wb_result, 32'd0);
    check("to_late_timeout", {31'b0, wb_timeout}, 32'd1);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    check("to_post_req_ready", {31'b0, req_ready}, 32'd1);
`else
    for (int c = 18; c < 30; c++) begin
      check("wait_forever_valid", {31'b0, wb_valid}, 32'd0);
      check("wait_forever_busy", {31'b0, busy}, 32'd1);
      step();
    end
    data_resultRDY = 1'b1; data_result = 32'd4; data_exception = 1'b0;
    step();
    data_resultRDY = 1'b0;
    check("late_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("late_wb_result", wb_result, 32'd4);
    check("late_wb_timeout", {31'b0, wb_timeout}, 32'd0);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    check("late_post_req_ready", {31'b0, req_ready}, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multdiv_issue.md
# multdiv_issue

Initiator-side controller for the shared multiply/divide unit. It accepts one request at a time from the pipeline, launches it with a single-cycle `ctrl_MULT`/`ctrl_DIV` pulse and stable operands, and waits for `data_resultRDY`. It then returns result, exception and destination tag on a valid/ready writeback port. It sits between decode/execute and the multdiv unit and provides the stall (`busy`) signal.

## Interface
- `TAG_W`, default 5: width of destination-register tag.
- `TIMEOUT_CYCLES`, default 64: watchdog limit in cycles. Used only with `MULTDIV_TIMEOUT_EN`.
- `clock`  in  1: sole clock, rising edge.
- `ctrl_reset_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: controller can accept.
- `req_op`  in  1: 0 = multiply, 1 = divide.
- `req_a`, `req_b`  in  32 each: operands.
- `req_tag`  in  `TAG_W`: destination tag.
- `data_operandA`, `data_operandB`  out  32 each: operands to multdiv.
- `ctrl_MULT`, `ctrl_DIV`  out  1 each: start pulses to multdiv.
- `data_result`  in  32: multdiv result.
- `data_exception`  in  1: multdiv exception.
- `data_resultRDY`  in  1: multdiv done.
- `wb_valid`  out  1: writeback valid.
- `wb_ready`  in  1: writeback consumer ready.
- `wb_result`  out  32: writeback result.
- `wb_exception`  out  1: writeback exception.
- `wb_tag`  out  `TAG_W`: writeback destination tag.
- `wb_timeout`  out  1: writeback timed out.
- `busy`  out  1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, GUARD, WAIT, DONE.
- IDLE
  - `req_ready`=1.
  - On `req_valid`, capture op/a/b/tag into internal registers and go to ISSUE.
- ISSUE (exactly 1 cycle)
  - Assert `ctrl_MULT` if op=0, `ctrl_DIV` if op=1. Never both.
  - Go to GUARD.
- GUARD (exactly 1 cycle)
  - `data_resultRDY` is ignored, because multdiv may still show a stale ready from the previous op.
  - Go to WAIT.
- WAIT
  - On `data_resultRDY`=1, register `data_result`→`wb_result`, `data_exception`→`wb_exception`, captured tag→`wb_tag`, then go to DONE.
- DONE
  - `wb_valid`=1; all wb outputs held stable.
  - When `wb_ready`=1, go to IDLE.
- `data_operandA`/`data_operandB` are driven from the captured registers from ISSUE through DONE. They are not changed while a request is outstanding.
- `req_valid` outside IDLE is ignored (`req_ready`=0).
- `data_resultRDY` is ignored in IDLE, ISSUE, GUARD and DONE.
- No request bypass: after the DONE handshake, the earliest next acceptance is the following cycle.
- Reset (any time, including mid-operation): asynchronously force IDLE.
- Reset values of outputs:
  - `ctrl_MULT`=0, `ctrl_DIV`=0.
  - `data_operandA`=0, `data_operandB`=0.
  - `wb_valid`=0, `wb_result`=0, `wb_exception`=0, `wb_tag`=0, `wb_timeout`=0.
  - `busy`=0, `req_ready`=1.

## Timing
- Request accepted at the cycle-0 edge.
- `ctrl_*` high during cycle 1 only.
- GUARD is cycle 2.
- `data_resultRDY` is honoured from cycle 3 onward.
- `data_resultRDY` sampled high in cycle k gives `wb_valid` high from cycle k+1. Minimum accept-to-`wb_valid` latency is 4 cycles.
- `wb_ready` already high when `wb_valid` rises completes the handshake in that same cycle. `req_ready` rises the next cycle.
- `busy`=1 from cycle 1 through the last DONE cycle.

## Configuration
- `MULTDIV_TIMEOUT_EN` defined:
  - A counter clears in ISSUE and increments each GUARD/WAIT cycle.
  - If `data_resultRDY` is not seen by cycle `TIMEOUT_CYCLES`+1 after acceptance, go to DONE with `wb_valid`=1, `wb_result`=0, `wb_exception`=1, `wb_timeout`=1.
  - A late `data_resultRDY` is ignored.
  - If `data_resultRDY` arrives in the final allowed cycle, it wins over the timeout.
- `MULTDIV_TIMEOUT_EN` undefined:
  - No counter; WAIT lasts indefinitely.
  - `wb_timeout` is tied to 0.

## Test plan
- Multiply: req_op=0, a=6, b=7, tag=3. Model raises `data_resultRDY` at cycle 10 with result 42.
  - Required: `ctrl_MULT` high only in cycle 1, `ctrl_DIV` stays 0, `wb_valid` at cycle 11 with `wb_result`=42, `wb_tag`=3, `wb_exception`=0.
- Divide by zero: req_op=1, a=100, b=0. Model returns exception=1.
  - Required: `ctrl_DIV` pulse only, `wb_exception`=1, operands held at 100/0 until DONE handshake.
- Stale ready: `data_resultRDY` held high through cycles 0–2, then low, then high at cycle 8.
  - Required: completion uses the cycle-8 value; `wb_valid` rises at cycle 9, not cycle 3.
- Backpressure: `wb_ready`=0 for 5 cycles after `wb_valid`, with `req_valid` asserted throughout.
  - Required: wb outputs stable, `req_ready`=0 until the handshake, next acceptance one cycle after it.
- Reset: assert `ctrl_reset_n`=0 in WAIT.
  - Required: immediate IDLE, `busy`=0, `req_ready`=1, `wb_valid`=0; a `data_resultRDY` pulse after release is ignored.
- With `MULTDIV_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, never raise `data_resultRDY`.
  - Required: `wb_valid` at cycle 18 with `wb_exception`=1, `wb_timeout`=1, `wb_result`=0.
  - Variant: `data_resultRDY` at cycle 17 gives a normal completion with `wb_timeout`=0.
